// File: rtl/sobol_rng_lsz_pkg.sv
// Shared helpers for the Sobol generator: index-width sizing, direction-vector slicing,
// and the default van der Corput direction-vector set.
package sobol_rng_lsz_pkg;

   // Width of an index into BW positions; never narrower than one bit.
   function automatic int log2w(input int bw);
      return (bw > 1) ? $clog2(bw) : 1;
   endfunction

   // Bit offset of direction vector k of channel ch inside the packed iDirVec bus.
   function automatic int dir_base(input int ch, input int k, input int bw);
      return (ch * bw + k) * bw;
   endfunction

   localparam int VDC_BITWIDTH = 4;

   function automatic logic [VDC_BITWIDTH*VDC_BITWIDTH-1:0] vdc_vec();
      logic [VDC_BITWIDTH*VDC_BITWIDTH-1:0] v;
      v = '0;
      for (int k = 0; k < VDC_BITWIDTH; k++)
         v[k*VDC_BITWIDTH +: VDC_BITWIDTH] = VDC_BITWIDTH'(1 << (VDC_BITWIDTH - 1 - k));
      return v;
   endfunction

   localparam logic [VDC_BITWIDTH*VDC_BITWIDTH-1:0] VDC_DIRVEC = vdc_vec();

endpackage

// File: rtl/sobol_rng_lsz_lsz_idx.sv
// Least-significant-zero locator: one-hot of the lowest 0 bit, its binary index,
// and a found flag that drops when the input is all ones.
module lsz_idx
   import sobol_rng_lsz_pkg::*;
#(
   parameter int BITWIDTH    = 4,
   parameter int LOGBITWIDTH = log2w(BITWIDTH)
) (
   input  logic [BITWIDTH-1:0]    iVal,
   output logic [BITWIDTH-1:0]    oOneHot,
   output logic [LOGBITWIDTH-1:0] oIdx,
   output logic                   oFound
);

   always_comb begin
      logic seen;
      seen    = 1'b0;
      oOneHot = '0;
      oIdx    = '0;
      // seen is a thermometer: set from the first zero bit upward
      for (int i = 0; i < BITWIDTH; i++) begin
         oOneHot[i] = ~iVal[i] & ~seen;
         seen       = seen | ~iVal[i];
      end
      for (int i = 0; i < BITWIDTH; i++)
         if (oOneHot[i]) oIdx = oIdx | LOGBITWIDTH'(i);
      oFound = seen;
   end

endmodule

// File: rtl/sobol_rng_lsz.sv
// Multi-channel Sobol low-discrepancy generator: one shared step counter, LSZ-indexed
// direction vectors XORed into each channel's running state, registered samples.
module sobol_rng_lsz
   import sobol_rng_lsz_pkg::*;
#(
   parameter int BITWIDTH    = 4,
   parameter int CHANNELS    = 2,
   parameter int LOGBITWIDTH = log2w(BITWIDTH)
) (
   input  logic                                  iClk,
   input  logic                                  iRst,
   input  logic                                  iClr,
   input  logic                                  iEn,
   input  logic [CHANNELS*BITWIDTH*BITWIDTH-1:0] iDirVec,
   output logic [CHANNELS*BITWIDTH-1:0]          oRand,
   output logic                                  oValid,
   output logic                                  oWrap
);

   logic [BITWIDTH-1:0]    cnt_q, cnt_d;
   logic                   valid_q, valid_d;
   logic                   wrap_q, wrap_d;
   logic [BITWIDTH-1:0]    onehot;
   logic [LOGBITWIDTH-1:0] idx;
   logic                   found;
   logic                   unused_onehot;

   lsz_idx #(
      .BITWIDTH    (BITWIDTH),
      .LOGBITWIDTH (LOGBITWIDTH)
   ) u_lsz (
      .iVal    (cnt_q),
      .oOneHot (onehot),
      .oIdx    (idx),
      .oFound  (found)
   );

   assign unused_onehot = ^onehot;

   // An all-ones counter is the last point of the period: restart at zero.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (iEn) begin
         cnt_d   = found ? cnt_q + 1'b1 : '0;
         valid_d = 1'b1;
         wrap_d  = ~found;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst || iClr) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign oValid = valid_q;
   assign oWrap  = wrap_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [BITWIDTH-1:0] state_q, state_d;
      logic [BITWIDTH-1:0] rand_q, rand_d;
      logic [BITWIDTH-1:0] dir;

      assign dir = iDirVec[dir_base(c, int'(idx), BITWIDTH) +: BITWIDTH];

      always_comb begin
         state_d = state_q;
         rand_d  = rand_q;
         if (iEn) begin
            rand_d  = state_q;
            state_d = found ? (state_q ^ dir) : '0;
         end
      end

      // Clear restarts the sequence but leaves the last sample on the output.
      always_ff @(posedge iClk) begin
         if (iRst) begin
            state_q <= '0;
            rand_q  <= '0;
         end else if (iClr) begin
            state_q <= '0;
         end else begin
            state_q <= state_d;
            rand_q  <= rand_d;
         end
      end

      assign oRand[c*BITWIDTH +: BITWIDTH] = rand_q;
   end

endmodule

// File: tb/tb_sobol_rng_lsz.sv
// Self-checking bench for sobol_rng_lsz: directed scenarios plus randomized control and
// direction vectors, compared against a Gray-code closed-form Sobol model.
module tb_sobol_rng_lsz;
   import sobol_rng_lsz_pkg::*;

   localparam int BW = 4;
   localparam int CH = 2;

   logic              iClk;
   logic              iRst, iClr, iEn;
   logic [CH*BW*BW-1:0] iDirVec;
   logic [CH*BW-1:0]  oRand;
   logic              oValid, oWrap;

   logic [BW-1:0] lv, l_onehot;
   logic [1:0]    l_idx;
   logic          l_found;

   sobol_rng_lsz #(.BITWIDTH(BW), .CHANNELS(CH)) dut (
      .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEn(iEn),
      .iDirVec(iDirVec), .oRand(oRand), .oValid(oValid), .oWrap(oWrap)
   );

   lsz_idx #(.BITWIDTH(BW)) u_lsz_tb (
      .iVal(lv), .oOneHot(l_onehot), .oIdx(l_idx), .oFound(l_found)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [BW-1:0] dv [CH][BW];
   int            m_n;
   logic [BW-1:0] m_rand [CH];
   logic          m_valid, m_wrap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Sample n of a Sobol dimension is the XOR of V[k] over set bits of gray(n).
   function automatic logic [BW-1:0] sobol(input int c, input int n);
      int g;
      logic [BW-1:0] x;
      g = n ^ (n >> 1);
      x = '0;
      for (int k = 0; k < BW; k++)
         if (g[k]) x = x ^ dv[c][k];
      return x;
   endfunction

   task automatic load_dv();
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < BW; k++)
            iDirVec[(c*BW + k)*BW +: BW] = dv[c][k];
   endtask

   task automatic step(input logic r, input logic cl, input logic e);
      iRst = r; iClr = cl; iEn = e;
      @(posedge iClk);
      if (r) begin
         m_n = 0; m_valid = 1'b0; m_wrap = 1'b0;
         for (int c = 0; c < CH; c++) m_rand[c] = '0;
      end else if (cl) begin
         m_n = 0; m_valid = 1'b0; m_wrap = 1'b0;
      end else if (e) begin
         for (int c = 0; c < CH; c++) m_rand[c] = sobol(c, m_n);
         m_valid = 1'b1;
         m_wrap  = (m_n == (1 << BW) - 1);
         m_n     = (m_n + 1) % (1 << BW);
      end else begin
         m_valid = 1'b0; m_wrap = 1'b0;
      end
      @(negedge iClk);
      check("valid", 32'(oValid), 32'(m_valid));
      check("wrap",  32'(oWrap),  32'(m_wrap));
      for (int c = 0; c < CH; c++)
         check($sformatf("rand_ch%0d", c), 32'(oRand[c*BW +: BW]), 32'(m_rand[c]));
   endtask

   int e0 [5] = '{0, 8, 12, 4, 6};
   int e1 [5] = '{0, 8, 4, 12, 6};
   logic [BW*BW-1:0] vdc;

   initial begin
      iRst = 1'b1; iClr = 1'b0; iEn = 1'b0; iDirVec = '0; lv = '0;
      m_n = 0; m_valid = 1'b0; m_wrap = 1'b0;
      for (int c = 0; c < CH; c++) m_rand[c] = '0;

      // lsz_idx standalone over every input value
      for (int v = 0; v < (1 << BW); v++) begin
         int m;
         lv = BW'(v);
         #1;
         m = (~v) & (v + 1) & ((1 << BW) - 1);
         check("lsz_found",  32'(l_found),  (v == 15) ? 0 : 1);
         check("lsz_onehot", 32'(l_onehot), 32'(m));
         check("lsz_idx",    32'(l_idx),    (v == 15) ? 0 : $clog2(m));
      end

      vdc = VDC_DIRVEC;
      for (int k = 0; k < BW; k++) dv[0][k] = vdc[k*BW +: BW];
      dv[1][0] = 4'd8; dv[1][1] = 4'd12; dv[1][2] = 4'd10; dv[1][3] = 4'd15;
      load_dv();

      step(1, 0, 0);
      step(1, 0, 1);
      check("reset_rand", 32'(oRand), 0);

      // five back-to-back steps from reset
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1);
         check("t1_ch0", 32'(oRand[0 +: BW]), e0[i]);
         check("t1_ch1", 32'(oRand[BW +: BW]), e1[i]);
      end

      // clear with enable: no sample, then restart from 0
      step(0, 1, 1);
      check("clr_valid", 32'(oValid), 0);
      step(0, 0, 1);
      check("clr_first", 32'(oRand), 0);

      // full period plus one
      step(0, 1, 0);
      for (int i = 1; i <= 17; i++) begin
         step(0, 0, 1);
         if (i == 16) begin
            check("wrap16", 32'(oWrap), 1);
            check("wrap16_ch0", 32'(oRand[0 +: BW]), 1);
         end
         if (i == 17) begin
            check("wrap17_wrap", 32'(oWrap), 0);
            check("wrap17_rand", 32'(oRand), 0);
         end
      end

      // gapped enables
      step(0, 1, 0);
      step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
      check("gap_ch0", 32'(oRand[0 +: BW]), 12);

      // reset mid-run with enable asserted
      step(0, 1, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 1);
      step(1, 0, 1);
      check("midrst", 32'(oRand), 0);
      step(0, 0, 1);
      step(0, 0, 1);
      check("midrst_ch0", 32'(oRand[0 +: BW]), 8);

      // randomized phases: new vectors only at a restart
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < CH; c++)
            for (int k = 0; k < BW; k++) dv[c][k] = BW'($urandom);
         load_dv();
         step(0, 1, 0);
         for (int i = 0; i < 150; i++)
            step($urandom_range(0, 127) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
